mem_port_arbiter: RTL and testbench

Sequences and shares the single unified instruction/data memory between the multicycle CPU datapath and the UART program loader. Each requester holds a request until a one-cycle ready pulse; the block serialises accesses, applies the fixed memory read latency, and returns registered read data. It also produces a stall for the control unit, which holds its state-machine advance while `cpu_stall` is high.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_port_arbiter_rr_arb2.sv | 28 ++
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the unified-memory port arbiter:
//   - arb_state_e : access sequencer states (IDLE, ISSUE, WAIT, RESP)
//   - REQ_CPU / REQ_LD : requester IDs, also used as bit positions in
//     the eligibility vector handed to the round-robin picker
//   - CNT_W : width of the memory-latency down counter
//   - lat_to_cnt : narrows an integer latency to the counter width
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LD  = 1'b1;

    localparam int CNT_W = 4;

    function automatic logic [CNT_W-1:0] lat_to_cnt(input int lat);
        return lat[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2
//   Combinational two-way round-robin pick.
//   Ports:
//     elig_i       [1:0] eligible requesters, indexed by requester ID
//     last_grant_i       ID granted most recently
//     grant_o            winning requester ID (meaningful when valid_o)
//     valid_o            at least one requester is eligible
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] elig_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = |elig_i;
        grant_o = REQ_CPU;
        if (elig_i == 2'b11) begin
            // Tie: the side that did not win last time goes first.
            grant_o = ~last_grant_i;
        end else if (elig_i[REQ_LD]) begin
            grant_o = REQ_LD;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one unified instruction/data memory between the CPU datapath
//   and the UART program loader. One access at a time is sequenced as
//   IDLE -> ISSUE (one mem_en strobe) -> WAIT (MEM_LAT cycles) -> RESP
//   (one-cycle ready pulse to the winner).
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     boot_mode_i                     blocks CPU requests from winning
//     cpu_req_i/we_i/addr_i/wdata_i   CPU request
//     cpu_rdata_o, cpu_ready_o        CPU response
//     cpu_stall_o                     cpu_req_i & ~cpu_ready_o (comb.)
//     ld_req_i/we_i/addr_i/wdata_i    loader request
//     ld_rdata_o, ld_ready_o          loader response
//     mem_en_o/we_o/addr_o/wdata_o    memory command (registered)
//     mem_rdata_i                     memory data, MEM_LAT after mem_en
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              boot_mode_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_ready_o,
    output logic              cpu_stall_o,
    input  logic              ld_req_i,
    input  logic              ld_we_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_wdata_i,
    output logic [DATA_W-1:0] ld_rdata_o,
    output logic              ld_ready_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [CNT_W-1:0] LAT_CNT = lat_to_cnt(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_e        state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q,      owner_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [DATA_W-1:0] rdata_q,      rdata_d;
    logic              mem_en_q,     mem_en_d;
    logic              mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic              cpu_ready_q,  cpu_ready_d;
    logic              ld_ready_q,   ld_ready_d;

    logic [1:0] elig;
    logic       arb_grant;
    logic       arb_valid;

    // The CPU is only a candidate outside boot mode; the loader always is.
    assign elig[REQ_CPU] = cpu_req_i & ~boot_mode_i;
    assign elig[REQ_LD]  = ld_req_i;

    rr_arb2 u_rr_arb2 (
        .elig_i       (elig),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .valid_o      (arb_valid)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        cpu_ready_d  = 1'b0;
        ld_ready_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    owner_d      = arb_grant;
                    last_grant_d = arb_grant;
                    // Latch the winner's command; it drives the memory
                    // pins directly from these registers during ISSUE.
                    if (arb_grant == REQ_LD) begin
                        mem_we_d = ld_we_i;
                        addr_d   = ld_addr_i;
                        wdata_d  = ld_wdata_i;
                    end else begin
                        mem_we_d = cpu_we_i;
                        addr_d   = cpu_addr_i;
                        wdata_d  = cpu_wdata_i;
                    end
                    mem_en_d = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = LAT_CNT;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                // Count value 1 marks the cycle in which the memory data
                // is valid, MEM_LAT cycles after the strobe.
                if (cnt_q == CNT_ONE) begin
                    rdata_d     = mem_rdata_i;
                    cpu_ready_d = (owner_q == REQ_CPU);
                    ld_ready_d  = (owner_q == REQ_LD);
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= REQ_LD;
            owner_q      <= REQ_CPU;
            cnt_q        <= '0;
            rdata_q      <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_ready_q  <= 1'b0;
            ld_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_ready_q  <= cpu_ready_d;
            ld_ready_q   <= ld_ready_d;
        end
    end

    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    assign cpu_ready_o = cpu_ready_q;
    assign ld_ready_o  = ld_ready_q;
    assign cpu_rdata_o = rdata_q;
    assign ld_rdata_o  = rdata_q;

    assign cpu_stall_o = cpu_req_i & ~cpu_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Two arbiter instances (MEM_LAT=1 and MEM_LAT=3), each with its own
//   memory model. Directed stimulus pushes expected memory strobes and
//   ready responses (with their cycle numbers) into per-instance queues;
//   monitors pop and compare whenever a strobe or ready appears.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        logic        id;
        logic        chk;
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } acc_t;

    rsp_t rsp_q [2][$];
    acc_t acc_q [2][$];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n     [2];
    logic        boot      [2];
    logic        cpu_req   [2];
    logic        cpu_we    [2];
    logic [31:0] cpu_addr  [2];
    logic [31:0] cpu_wdata [2];
    logic [31:0] cpu_rdata [2];
    logic        cpu_ready [2];
    logic        cpu_stall [2];
    logic        ld_req    [2];
    logic        ld_we     [2];
    logic [31:0] ld_addr   [2];
    logic [31:0] ld_wdata  [2];
    logic [31:0] ld_rdata  [2];
    logic        ld_ready  [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            localparam int LAT = (gi == 0) ? 1 : 3;

            mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
                .clk         (clk),
                .rst_n       (rst_n[gi]),
                .boot_mode_i (boot[gi]),
                .cpu_req_i   (cpu_req[gi]),
                .cpu_we_i    (cpu_we[gi]),
                .cpu_addr_i  (cpu_addr[gi]),
                .cpu_wdata_i (cpu_wdata[gi]),
                .cpu_rdata_o (cpu_rdata[gi]),
                .cpu_ready_o (cpu_ready[gi]),
                .cpu_stall_o (cpu_stall[gi]),
                .ld_req_i    (ld_req[gi]),
                .ld_we_i     (ld_we[gi]),
                .ld_addr_i   (ld_addr[gi]),
                .ld_wdata_i  (ld_wdata[gi]),
                .ld_rdata_o  (ld_rdata[gi]),
                .ld_ready_o  (ld_ready[gi]),
                .mem_en_o    (mem_en[gi]),
                .mem_we_o    (mem_we[gi]),
                .mem_addr_o  (mem_addr[gi]),
                .mem_wdata_o (mem_wdata[gi]),
                .mem_rdata_i (mem_rdata[gi])
            );

            // Memory: read data is valid exactly LAT cycles after a read strobe.
            logic [31:0] mem  [256];
            logic [31:0] pipe [LAT];
            always @(posedge clk) begin
                if (cyc == 0) begin
                    mem[8'h40] <= 32'hDEADBEEF;
                    mem[8'h44] <= 32'h11111111;
                    mem[8'h48] <= 32'h22222222;
                end else if (mem_en[gi] && mem_we[gi]) begin
                    mem[mem_addr[gi][7:0]] <= mem_wdata[gi];
                end
                pipe[0] <= (mem_en[gi] && !mem_we[gi]) ? mem[mem_addr[gi][7:0]] : 32'hBAD0BAD0;
                for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
            end
            assign mem_rdata[gi] = pipe[LAT-1];

            rsp_t mon_r;
            acc_t mon_a;
            always @(negedge clk) begin
                if (cpu_ready[gi] || ld_ready[gi]) begin
                    if (cpu_ready[gi] && ld_ready[gi]) begin
                        fail_evt($sformatf("d%0d_both_ready", gi));
                    end else if (rsp_q[gi].size() == 0) begin
                        fail_evt($sformatf("d%0d_ready_no_request", gi));
                    end else begin
                        mon_r = rsp_q[gi].pop_front();
                        check($sformatf("d%0d_rsp_id", gi), 64'(ld_ready[gi]), 64'(mon_r.id));
                        check($sformatf("d%0d_rsp_cycle", gi), 64'(cyc), 64'(mon_r.cyc));
                        if (mon_r.chk)
                            check($sformatf("d%0d_rsp_data", gi),
                                  64'(ld_ready[gi] ? ld_rdata[gi] : cpu_rdata[gi]), 64'(mon_r.data));
                    end
                end
                if (mem_en[gi]) begin
                    if (acc_q[gi].size() == 0) begin
                        fail_evt($sformatf("d%0d_strobe_no_request", gi));
                    end else begin
                        mon_a = acc_q[gi].pop_front();
                        check($sformatf("d%0d_acc_we", gi), 64'(mem_we[gi]), 64'(mon_a.we));
                        check($sformatf("d%0d_acc_addr", gi), 64'(mem_addr[gi]), 64'(mon_a.addr));
                        check($sformatf("d%0d_acc_cycle", gi), 64'(cyc), 64'(mon_a.cyc));
                        if (mon_a.we)
                            check($sformatf("d%0d_acc_wdata", gi), 64'(mem_wdata[gi]), 64'(mon_a.wdata));
                    end
                end
            end
        end
    endgenerate

    task automatic exp_rsp(input int d, input logic id, input logic chk, input logic [31:0] data, input int c);
        rsp_t r;
        r.id = id; r.chk = chk; r.data = data; r.cyc = c;
        rsp_q[d].push_back(r);
    endtask

    task automatic exp_acc(input int d, input logic we, input logic [31:0] a, input logic [31:0] w, input int c);
        acc_t x;
        x.we = we; x.addr = a; x.wdata = w; x.cyc = c;
        acc_q[d].push_back(x);
    endtask

    task automatic set_cpu(input int d, input logic req, input logic we, input logic [31:0] a, input logic [31:0] w);
        cpu_req[d] = req; cpu_we[d] = we; cpu_addr[d] = a; cpu_wdata[d] = w;
    endtask

    task automatic set_ld(input int d, input logic req, input logic we, input logic [31:0] a, input logic [31:0] w);
        ld_req[d] = req; ld_we[d] = we; ld_addr[d] = a; ld_wdata[d] = w;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input int d, input string tag);
        check($sformatf("%s_d%0d_mem_en", tag, d), 64'(mem_en[d]), 64'd0);
        check($sformatf("%s_d%0d_cpu_ready", tag, d), 64'(cpu_ready[d]), 64'd0);
        check($sformatf("%s_d%0d_ld_ready", tag, d), 64'(ld_ready[d]), 64'd0);
    endtask

    // Reset asserted part-way through a CPU read, 'off' cycles after the request.
    task automatic reset_mid(input int d, input int off);
        int t;
        @(negedge clk);
        t = cyc;
        set_cpu(d, 1'b1, 1'b0, 32'h40, 32'h0);
        exp_acc(d, 1'b0, 32'h40, 32'h0, t + 1);
        wait_to(t + off);
        #2 rst_n[d] = 1'b0;
        #1 check_idle_outputs(d, "rst_mid");
        set_cpu(d, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_to(t + off + 1);
        rst_n[d] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            wait_to(t + off + 1 + k);
            #1 check_idle_outputs(d, "rst_after");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b1;
            boot[d]  = 1'b0;
            set_cpu(d, 1'b0, 1'b0, 32'h0, 32'h0);
            set_ld(d, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        #1;
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_idle_outputs(d, "reset");
            check($sformatf("reset_d%0d_mem_we", d), 64'(mem_we[d]), 64'd0);
            check($sformatf("reset_d%0d_mem_addr", d), 64'(mem_addr[d]), 64'd0);
            check($sformatf("reset_d%0d_mem_wdata", d), 64'(mem_wdata[d]), 64'd0);
            check($sformatf("reset_d%0d_rdata", d), 64'(cpu_rdata[d]), 64'd0);
            check($sformatf("reset_d%0d_stall", d), 64'(cpu_stall[d]), 64'd0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // CPU read 0x40, latency 1: strobe t+1, ready t+3, stall t..t+2.
        @(negedge clk);
        t = cyc;
        set_cpu(0, 1'b1, 1'b0, 32'h40, 32'h0);
        exp_acc(0, 1'b0, 32'h40, 32'h0, t + 1);
        exp_rsp(0, REQ_CPU, 1'b1, 32'hDEADBEEF, t + 3);
        for (int k = 0; k < 3; k++) begin
            wait_to(t + k);
            #1 check("cpu_read_stall_high", 64'(cpu_stall[0]), 64'd1);
        end
        wait_to(t + 3);
        #1 check("cpu_read_stall_low", 64'(cpu_stall[0]), 64'd0);
        set_cpu(0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Fresh reset so the tie-break starts with CPU preferred.
        @(negedge clk);
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;

        // Simultaneous requests: CPU first, loader next.
        @(negedge clk);
        t = cyc;
        set_cpu(0, 1'b1, 1'b0, 32'h44, 32'h0);
        set_ld(0, 1'b1, 1'b0, 32'h48, 32'h0);
        exp_acc(0, 1'b0, 32'h44, 32'h0, t + 1);
        exp_rsp(0, REQ_CPU, 1'b1, 32'h11111111, t + 3);
        exp_acc(0, 1'b0, 32'h48, 32'h0, t + 5);
        exp_rsp(0, REQ_LD, 1'b1, 32'h22222222, t + 7);
        wait_to(t + 3);
        set_cpu(0, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_to(t + 7);
        set_ld(0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Both held continuously: CPU, LD, CPU.
        @(negedge clk);
        t = cyc;
        set_cpu(0, 1'b1, 1'b0, 32'h44, 32'h0);
        set_ld(0, 1'b1, 1'b0, 32'h48, 32'h0);
        exp_acc(0, 1'b0, 32'h44, 32'h0, t + 1);
        exp_rsp(0, REQ_CPU, 1'b1, 32'h11111111, t + 3);
        exp_acc(0, 1'b0, 32'h48, 32'h0, t + 5);
        exp_rsp(0, REQ_LD, 1'b1, 32'h22222222, t + 7);
        exp_acc(0, 1'b0, 32'h44, 32'h0, t + 9);
        exp_rsp(0, REQ_CPU, 1'b1, 32'h11111111, t + 11);
        wait_to(t + 11);
        set_cpu(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_ld(0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Boot mode: only the loader wins; CPU write proceeds once boot drops.
        @(negedge clk);
        t = cyc;
        boot[0] = 1'b1;
        set_cpu(0, 1'b1, 1'b1, 32'h50, 32'hCAFEF00D);
        set_ld(0, 1'b1, 1'b0, 32'h48, 32'h0);
        exp_acc(0, 1'b0, 32'h48, 32'h0, t + 1);
        exp_rsp(0, REQ_LD, 1'b1, 32'h22222222, t + 3);
        exp_acc(0, 1'b1, 32'h50, 32'hCAFEF00D, t + 7);
        exp_rsp(0, REQ_CPU, 1'b0, 32'h0, t + 9);
        wait_to(t + 3);
        set_ld(0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 4; k <= 6; k++) begin
            wait_to(t + k);
            #1 check("boot_cpu_stalled", 64'(cpu_stall[0]), 64'd1);
        end
        boot[0] = 1'b0;
        wait_to(t + 9);
        set_cpu(0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Read back the CPU write.
        @(negedge clk);
        t = cyc;
        set_cpu(0, 1'b1, 1'b0, 32'h50, 32'h0);
        exp_acc(0, 1'b0, 32'h50, 32'h0, t + 1);
        exp_rsp(0, REQ_CPU, 1'b1, 32'hCAFEF00D, t + 3);
        wait_to(t + 3);
        set_cpu(0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset during WAIT (latency 1 instance).
        reset_mid(0, 2);

        // Loader write, latency 3: ready at t+5, CPU ready stays low.
        @(negedge clk);
        t = cyc;
        set_ld(1, 1'b1, 1'b1, 32'h10, 32'h12345678);
        exp_acc(1, 1'b1, 32'h10, 32'h12345678, t + 1);
        exp_rsp(1, REQ_LD, 1'b0, 32'h0, t + 5);
        wait_to(t + 5);
        #1 check("ld_write_cpu_ready_low", 64'(cpu_ready[1]), 64'd0);
        set_ld(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Latency 3 reads: CPU 0x40 then loader reads back 0x10.
        @(negedge clk);
        t = cyc;
        set_cpu(1, 1'b1, 1'b0, 32'h40, 32'h0);
        exp_acc(1, 1'b0, 32'h40, 32'h0, t + 1);
        exp_rsp(1, REQ_CPU, 1'b1, 32'hDEADBEEF, t + 5);
        wait_to(t + 5);
        set_cpu(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        t = cyc;
        set_ld(1, 1'b1, 1'b0, 32'h10, 32'h0);
        exp_acc(1, 1'b0, 32'h10, 32'h0, t + 1);
        exp_rsp(1, REQ_LD, 1'b1, 32'h12345678, t + 5);
        wait_to(t + 5);
        set_ld(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset during the strobe cycle (latency 3 instance).
        reset_mid(1, 1);

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_leftover_rsp", d), 64'(rsp_q[d].size()), 64'd0);
            check($sformatf("d%0d_leftover_acc", d), 64'(acc_q[d].size()), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
